// File: rtl/sum_range_caller_pkg.sv
// Shared types and defaults for the range-generator caller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sum_range_caller_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_COUNT_W = 32;

  typedef enum logic [1:0] {
    LAUNCH  = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sum_range_caller.sv
// Drives an external range generator and reduces its output stream to sum and count.
// Latency: gen_start one cycle after _start; _valid one cycle after gen_done seen with gen_valid low.
// Backpressure: result held in EMIT until _ready; generator throttled via gen_ready.
//
// Ports:
//   _clock, _reset        clock (posedge) and synchronous active-high reset
//   _start, base/limit/step   launch request and generator arguments
//   _ready/_valid/_done, _0 (sum), _1 (count)   parent-facing generator protocol
//   gen_base/limit/step, gen_start, gen_reset, gen_ready   to the generator
//   gen_valid, gen_done, gen_0                              from the generator
// Build option: define SUM_RANGE_CALLER_THROTTLE_EN to alternate gen_ready 1,0,1,0 in COLLECT.
module sum_range_caller
  import sum_range_caller_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               _clock,
  input  logic               _reset,
  input  logic               _start,
  input  logic [WIDTH-1:0]   base,
  input  logic [WIDTH-1:0]   limit,
  input  logic [WIDTH-1:0]   step,
  input  logic               _ready,
  output logic               _valid,
  output logic               _done,
  output logic [WIDTH-1:0]   _0,
  output logic [COUNT_W-1:0] _1,
  output logic [WIDTH-1:0]   gen_base,
  output logic [WIDTH-1:0]   gen_limit,
  output logic [WIDTH-1:0]   gen_step,
  output logic               gen_start,
  output logic               gen_reset,
  output logic               gen_ready,
  input  logic               gen_valid,
  input  logic               gen_done,
  input  logic [WIDTH-1:0]   gen_0
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sum;
  logic [COUNT_W-1:0] count;
  logic               ready_phase;
  logic               xfer;
  logic               finish;

`ifdef SUM_RANGE_CALLER_THROTTLE_EN
  // Low on COLLECT entry so the first COLLECT cycle offers gen_ready=1.
  logic throttle_q;

  always_ff @(posedge _clock) begin
    if (_start || _reset) begin
      throttle_q <= 1'b0;
    end else if (state == COLLECT) begin
      throttle_q <= ~throttle_q;
    end else begin
      throttle_q <= 1'b0;
    end
  end

  assign ready_phase = ~throttle_q;
`else
  assign ready_phase = 1'b1;
`endif

  // _start wins over _reset so a parent can restart in the same cycle it resets.
  always_ff @(posedge _clock) begin
    if (_start) begin
      state <= LAUNCH;
    end else if (_reset) begin
      state <= DONE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gen_start = 1'b0;
    gen_ready = 1'b0;
    xfer      = 1'b0;
    finish    = 1'b0;
    case (state)
      LAUNCH: begin
        gen_start = 1'b1;
        state_nxt = COLLECT;
      end
      COLLECT: begin
        gen_ready = ready_phase;
        xfer      = gen_valid && ready_phase;
        // A final element arriving alongside gen_done is taken first; exit
        // only once the generator reports done with nothing pending.
        if (ready_phase && gen_done && !gen_valid) begin
          finish    = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (_ready) begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = DONE;
      end
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_start) begin
      gen_base  <= base;
      gen_limit <= limit;
      gen_step  <= step;
      sum       <= '0;
      count     <= '0;
      _valid    <= 1'b0;
      _done     <= 1'b0;
      gen_reset <= 1'b0;
    end else if (_reset) begin
      gen_base  <= '0;
      gen_limit <= '0;
      gen_step  <= '0;
      sum       <= '0;
      count     <= '0;
      _0        <= '0;
      _1        <= '0;
      _valid    <= 1'b0;
      _done     <= 1'b0;
      gen_reset <= 1'b1;
    end else begin
      gen_reset <= 1'b0;
      _done     <= (state_nxt == DONE);
      if (xfer) begin
        sum   <= sum + gen_0;
        count <= count + COUNT_W'(1);
      end
      if (finish) begin
        _0     <= sum;
        _1     <= count;
        _valid <= 1'b1;
      end else if (state == EMIT && _ready) begin
        _valid <= 1'b0;
      end
    end
  end

endmodule
